// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs field-level RV32 R/load/store/branch requests into 32-bit
//            words and writes them to consecutive instruction-memory words.
//            Optional macro ENCODER_RANGE_CHECK_EN enables immediate checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_sub,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [12:0]      in_imm,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err
);

  localparam logic [6:0]       OP_R      = 7'b0110011;
  localparam logic [6:0]       OP_LOAD   = 7'b0000011;
  localparam logic [6:0]       OP_STORE  = 7'b0100011;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [31:0]      enc_word;
  logic             reject;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    enc_word = 32'h0;
    case (in_class)
      2'b00:   enc_word = {(in_sub ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1,
                           in_funct3, in_rd, OP_R};
      2'b01:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      2'b10:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:0], OP_STORE};
      default: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Load/store immediates must fit 12-bit signed; branch offsets must be even.
  always_comb begin
    reject = 1'b0;
    case (in_class)
      2'b01, 2'b10: reject = (in_imm[12] != in_imm[11]);
      2'b11:        reject = in_imm[0];
      default:      reject = 1'b0;
    endcase
  end
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = in_imm[0];
  assign reject         = 1'b0;
`endif

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            wdata_d = enc_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_inc;
          state_d = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
        end
      end
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    // Registered so in_ready stays low through reset and rises one edge later.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = (state_q == S_FULL);
  assign err       = err_q;

endmodule

`default_nettype wire
